// File: rtl/pe_output_collector_if.sv
// Handshake bundle between the PE, the output collector and the downstream consumer.
interface pe_output_collector_if #(
   parameter int DATA_WIDTH = 16
);
   logic [DATA_WIDTH-1:0] pe_out;
   logic                  pe_compute_done;
   logic [DATA_WIDTH-1:0] out_data;
   logic                  out_valid;
   logic                  out_ready;
   logic                  fifo_full;
   logic                  frame_done;
   logic                  overflow;

   modport master (
      output pe_out, pe_compute_done, out_ready,
      input  out_data, out_valid, fifo_full, frame_done, overflow
   );

   modport slave (
      input  pe_out, pe_compute_done, out_ready,
      output out_data, out_valid, fifo_full, frame_done, overflow
   );
endinterface

// File: rtl/pe_output_collector.sv
// Sums NUM_CHANNELS PE results per output, saturates, optionally clamps negatives (PE_COLLECT_RELU_EN)
// and queues results in a FIFO for a valid/ready consumer; flags the last result of each frame.
module pe_output_collector #(
   parameter int DATA_WIDTH   = 16,
   parameter int NUM_CHANNELS = 1,
   parameter int NUM_OUTPUTS  = 3,
   parameter int FIFO_DEPTH   = 4
) (
   input logic                clk,
   input logic                reset,
   pe_output_collector_if.slave bus
);
   localparam int ACC_W = DATA_WIDTH + $clog2(NUM_CHANNELS) + 1;
   localparam int CH_W  = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
   localparam int OC_W  = (NUM_OUTPUTS > 1) ? $clog2(NUM_OUTPUTS) : 1;
   localparam int AW    = $clog2(FIFO_DEPTH);

   localparam logic [CH_W-1:0] CH_LAST = CH_W'(NUM_CHANNELS - 1);
   localparam logic [OC_W-1:0] OC_LAST = OC_W'(NUM_OUTPUTS - 1);
   localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

   typedef enum logic [0:0] {ST_ACCUM, ST_PUSH} state_e;

   state_e                  state_q, state_d;
   logic                    done_q, done_d;
   logic signed [ACC_W-1:0] acc_q, acc_d;
   logic [CH_W-1:0]         chan_cnt_q, chan_cnt_d;
   logic [OC_W-1:0]         out_cnt_q, out_cnt_d;
   logic [DATA_WIDTH-1:0]   res_q, res_d;
   logic [AW:0]             wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [DATA_WIDTH-1:0]   mem_q [FIFO_DEPTH];
   logic [DATA_WIDTH-1:0]   mem_d [FIFO_DEPTH];
   logic                    frame_done_q, frame_done_d;
   logic                    overflow_q, overflow_d;

   logic                    evt, push, pop, fifo_full, fifo_empty;
   logic signed [ACC_W-1:0] pe_ext, sum, sat;
   logic [DATA_WIDTH-1:0]   res_val;

   assign fifo_empty = (wr_ptr_q == rd_ptr_q);
   assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

   always_comb begin
      state_d      = ST_ACCUM;
      done_d       = bus.pe_compute_done;
      acc_d        = acc_q;
      chan_cnt_d   = chan_cnt_q;
      out_cnt_d    = out_cnt_q;
      res_d        = res_q;
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      mem_d        = mem_q;
      frame_done_d = 1'b0;
      overflow_d   = overflow_q;

      evt    = bus.pe_compute_done && !done_q;
      pe_ext = {{(ACC_W-DATA_WIDTH){bus.pe_out[DATA_WIDTH-1]}}, bus.pe_out};
      sum    = acc_q + pe_ext;
      sat    = sum;
      if (sum > SAT_MAX) sat = SAT_MAX;
      if (sum < SAT_MIN) sat = SAT_MIN;
`ifdef PE_COLLECT_RELU_EN
      res_val = sat[ACC_W-1] ? '0 : sat[DATA_WIDTH-1:0];
`else
      res_val = sat[DATA_WIDTH-1:0];
`endif

      // Accumulation runs in either state so an event landing in PUSH is not lost.
      if (evt) begin
         if (chan_cnt_q == CH_LAST) begin
            res_d      = res_val;
            acc_d      = '0;
            chan_cnt_d = '0;
            state_d    = ST_PUSH;
         end else begin
            acc_d      = sum;
            chan_cnt_d = chan_cnt_q + CH_W'(1);
         end
      end

      pop  = !fifo_empty && bus.out_ready;
      push = (state_q == ST_PUSH) && (!fifo_full || pop);

      if (state_q == ST_PUSH) begin
         if (push) begin
            mem_d[wr_ptr_q[AW-1:0]] = res_q;
            wr_ptr_d = wr_ptr_q + (AW+1)'(1);
         end else begin
            overflow_d = 1'b1;
         end
         if (out_cnt_q == OC_LAST) begin
            out_cnt_d    = '0;
            frame_done_d = 1'b1;
         end else begin
            out_cnt_d = out_cnt_q + OC_W'(1);
         end
      end

      if (pop) rd_ptr_d = rd_ptr_q + (AW+1)'(1);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_ACCUM;
         done_q       <= 1'b0;
         acc_q        <= '0;
         chan_cnt_q   <= '0;
         out_cnt_q    <= '0;
         res_q        <= '0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         mem_q        <= '{default: '0};
         frame_done_q <= 1'b0;
         overflow_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         done_q       <= done_d;
         acc_q        <= acc_d;
         chan_cnt_q   <= chan_cnt_d;
         out_cnt_q    <= out_cnt_d;
         res_q        <= res_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         mem_q        <= mem_d;
         frame_done_q <= frame_done_d;
         overflow_q   <= overflow_d;
      end
   end

   assign bus.out_data   = mem_q[rd_ptr_q[AW-1:0]];
   assign bus.out_valid  = !fifo_empty;
   assign bus.fifo_full  = fifo_full;
   assign bus.frame_done = frame_done_q;
   assign bus.overflow   = overflow_q;
endmodule

// File: tb/tb_pe_output_collector.sv
// Directed and randomized bench for pe_output_collector against a queue-based reference model;
// covers a 1-channel and a 3-channel instance.
module tb_pe_output_collector;
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   pe_output_collector_if #(.DATA_WIDTH(16)) bus1 ();
   pe_output_collector_if #(.DATA_WIDTH(16)) bus3 ();

   pe_output_collector #(.DATA_WIDTH(16), .NUM_CHANNELS(1), .NUM_OUTPUTS(3), .FIFO_DEPTH(4)) u_dut1 (
      .clk(clk), .reset(reset), .bus(bus1.slave));
   pe_output_collector #(.DATA_WIDTH(16), .NUM_CHANNELS(3), .NUM_OUTPUTS(2), .FIFO_DEPTH(4)) u_dut3 (
      .clk(clk), .reset(reset), .bus(bus3.slave));

   int checks = 0;
   int errors = 0;
   int sel, nch, nout;
   int psum, pcnt, ocnt;
   bit ovf;
   logic [15:0] q[$];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drv(input logic [15:0] v, input logic d, input logic r);
      if (sel == 0) begin
         bus1.pe_out = v; bus1.pe_compute_done = d; bus1.out_ready = r;
      end else begin
         bus3.pe_out = v; bus3.pe_compute_done = d; bus3.out_ready = r;
      end
   endtask

   function automatic logic [15:0] o_data();  return (sel == 0) ? bus1.out_data   : bus3.out_data;   endfunction
   function automatic logic        o_valid(); return (sel == 0) ? bus1.out_valid  : bus3.out_valid;  endfunction
   function automatic logic        o_full();  return (sel == 0) ? bus1.fifo_full  : bus3.fifo_full;  endfunction
   function automatic logic        o_fd();    return (sel == 0) ? bus1.frame_done : bus3.frame_done; endfunction
   function automatic logic        o_ovf();   return (sel == 0) ? bus1.overflow   : bus3.overflow;   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d (dut sel=%0d)", tag, obs, exp, sel);
      end
   endtask

   task automatic check_status(input string tag);
      check({tag, "_valid"}, 32'(o_valid()), 32'(q.size() > 0));
      check({tag, "_full"}, 32'(o_full()), 32'(q.size() == 4));
      check({tag, "_overflow"}, 32'(o_ovf()), 32'(ovf));
      if (q.size() > 0) check({tag, "_data"}, 32'(o_data()), 32'(q[0]));
   endtask

   function automatic logic [15:0] model_result(input int s);
      int r;
      r = s;
      if (r > 32767) r = 32767;
      if (r < -32768) r = -32768;
`ifdef PE_COLLECT_RELU_EN
      if (r < 0) r = 0;
`endif
      return 16'(r);
   endfunction

   task automatic do_reset();
      bus1.pe_out = '0; bus1.pe_compute_done = 1'b0; bus1.out_ready = 1'b0;
      bus3.pe_out = '0; bus3.pe_compute_done = 1'b0; bus3.out_ready = 1'b0;
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      psum = 0; pcnt = 0; ocnt = 0; ovf = 0;
      q.delete();
   endtask

   // One PE compute_done edge with the level held for 'hold' cycles; optionally pop during PUSH.
   task automatic pe_event(input logic [15:0] v, input int hold, input bit pop_push);
      bit complete;
      bit fd;
      logic [15:0] r;
      r = '0;
      drv(v, 1'b1, 1'b0);
      tick();
      psum += int'($signed(v));
      pcnt++;
      complete = (pcnt == nch);
      if (complete) begin
         r = model_result(psum);
         psum = 0;
         pcnt = 0;
      end
      if (complete && pop_push && q.size() > 0) begin
         drv(v, hold > 1, 1'b1);
         check("push_cycle_head", 32'(o_data()), 32'(q[0]));
         void'(q.pop_front());
      end else begin
         drv(v, hold > 1, 1'b0);
      end
      tick();
      drv(v, hold > 2, 1'b0);
      fd = 1'b0;
      if (complete) begin
         if (q.size() < 4) q.push_back(r);
         else ovf = 1'b1;
         ocnt++;
         if (ocnt == nout) begin
            fd = 1'b1;
            ocnt = 0;
         end
      end
      check("frame_done", 32'(o_fd()), 32'(fd));
      check_status("after_push");
      for (int i = 2; i < hold; i++) begin
         tick();
         drv(v, (i + 1) < hold, 1'b0);
      end
      tick();
      check("frame_done_pulse", 32'(o_fd()), 32'(0));
      tick();
      tick();
      tick();
      check_status("after_idle");
   endtask

   task automatic drain(input int n);
      int k;
      k = (n > q.size()) ? q.size() : n;
      for (int i = 0; i < k; i++) begin
         drv('0, 1'b0, 1'b1);
         check("drain_valid", 32'(o_valid()), 32'(1));
         check("drain_data", 32'(o_data()), 32'(q[0]));
         tick();
         void'(q.pop_front());
      end
      drv('0, 1'b0, 1'b0);
      check_status("after_drain");
   endtask

   initial begin
      sel = 0; nch = 1; nout = 3;
      do_reset();
      for (int s = 0; s < 2; s++) begin
         sel = s;
         check("reset_data", 32'(o_data()), 32'(0));
         check("reset_valid", 32'(o_valid()), 32'(0));
         check("reset_full", 32'(o_full()), 32'(0));
         check("reset_frame_done", 32'(o_fd()), 32'(0));
         check("reset_overflow", 32'(o_ovf()), 32'(0));
      end

      // Single-channel instance
      sel = 0; nch = 1; nout = 3;
      pe_event(16'd5, 1, 1'b0);
      pe_event(16'hFFF9, 1, 1'b0);
      pe_event(16'd9, 1, 1'b0);
      drain(3);

      pe_event(16'd3, 4, 1'b0);
      drain(1);

      repeat (5) pe_event(16'($urandom), 1, 1'b0);
      check("overflow_set", 32'(o_ovf()), 32'(1));
      drain(4);
      check("overflow_sticky", 32'(o_ovf()), 32'(1));

      pe_event(16'($urandom), 1, 1'b0);
      pe_event(16'($urandom), 1, 1'b0);
      do_reset();
      check("midreset_valid", 32'(o_valid()), 32'(0));
      check("midreset_full", 32'(o_full()), 32'(0));
      check("midreset_overflow", 32'(o_ovf()), 32'(0));
      repeat (3) pe_event(16'($urandom), 1, 1'b0);
      drain(3);

      repeat (4) pe_event(16'($urandom), 1, 1'b0);
      pe_event(16'($urandom), 1, 1'b1);
      check("full_pop_full", 32'(o_full()), 32'(1));
      check("full_pop_overflow", 32'(o_ovf()), 32'(0));
      drain(4);

      repeat (25) begin
         pe_event(16'($urandom), int'($urandom_range(1, 3)), bit'($urandom_range(0, 1)));
         if ($urandom_range(0, 2) == 0) drain(int'($urandom_range(0, q.size())));
      end
      drain(q.size());

      // Three-channel instance
      sel = 1; nch = 3; nout = 2;
      do_reset();
      pe_event(16'd30000, 1, 1'b0);
      pe_event(16'd30000, 1, 1'b0);
      check("partial_no_push", 32'(o_valid()), 32'(0));
      pe_event(16'd10, 1, 1'b0);
      check("sat_pos", 32'(o_data()), 32'(16'd32767));
      drain(1);
      repeat (3) pe_event(16'(-30000), 1, 1'b0);
      drain(1);

      repeat (36) begin
         pe_event(16'($urandom), 1, bit'($urandom_range(0, 1)));
         if ($urandom_range(0, 3) == 0) drain(int'($urandom_range(0, q.size())));
      end
      drain(q.size());

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
